// File: rtl/aoi221_sweep_pkg.sv
// Shared types, widths and the aoi221 reference function for the sweep checker.
package aoi221_sweep_pkg;

  localparam int unsigned VEC_W   = 5;
  localparam int unsigned ERR_W   = 6;
  localparam int unsigned ERR_MAX = 63;
  localparam int unsigned PASS_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Expected cell output for vector {A1,A2,B1,B2,C}.
  function automatic logic aoi221_expect(input logic [VEC_W-1:0] vec);
    return ~((vec[4] & vec[3]) | (vec[2] & vec[1]) | vec[0]);
  endfunction

endpackage

// File: rtl/aoi221_sweep_vecgen.sv
// Sweep index to applied-vector mapping; AOI221_SWEEP_GRAY_EN selects Gray order.
module aoi221_sweep_vecgen
  import aoi221_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] idx,
  output logic [VEC_W-1:0] vec_c
);

`ifdef AOI221_SWEEP_GRAY_EN
  assign vec_c = idx ^ (idx >> 1);
`else
  assign vec_c = idx;
`endif

endmodule

// File: rtl/aoi221_sweep_checker.sv
// Sweeps all 32 aoi221 input vectors NPASS times, checks ZN after a settle
// time and reports mismatch count and first failing vector.
// Optional Gray-order sweep: define AOI221_SWEEP_GRAY_EN.
module aoi221_sweep_checker
  import aoi221_sweep_pkg::*;
#(
  parameter int unsigned NPASS    = 1,
  parameter int unsigned SETTLE_W = 4
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic                START,
  input  logic [SETTLE_W-1:0] SETTLE,
  output logic                A1,
  output logic                A2,
  output logic                B1,
  output logic                B2,
  output logic                C,
  input  logic                ZN,
  output logic                BUSY,
  output logic                DONE,
  output logic                PASS,
  output logic [ERR_W-1:0]    ERR_CNT,
  output logic [VEC_W-1:0]    FIRST_FAIL
);

  state_t              state;
  logic [SETTLE_W-1:0] s;
  logic [SETTLE_W-1:0] cnt;
  logic [VEC_W-1:0]    idx;
  logic [VEC_W-1:0]    idx_nxt;
  logic [VEC_W-1:0]    vec;
  logic [VEC_W-1:0]    vec_nxt;
  logic [PASS_W-1:0]   pass_cnt;
  logic [ERR_W-1:0]    err_nxt;
  logic                mismatch;

  // Index of the vector applied next: successor in CHECK (wraps 31->0), else 0.
  assign idx_nxt = (state == ST_CHECK) ? idx + VEC_W'(1) : '0;

  aoi221_sweep_vecgen u_vecgen (
    .idx   (idx_nxt),
    .vec_c (vec_nxt)
  );

  assign mismatch = (ZN != aoi221_expect(vec));
  assign err_nxt  = (mismatch && (ERR_CNT != ERR_W'(ERR_MAX))) ? ERR_CNT + ERR_W'(1) : ERR_CNT;

  assign {A1, A2, B1, B2, C} = vec;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state      <= ST_IDLE;
      s          <= '0;
      cnt        <= '0;
      idx        <= '0;
      vec        <= '0;
      pass_cnt   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FIRST_FAIL <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            s          <= SETTLE;
            cnt        <= SETTLE;
            idx        <= '0;
            vec        <= vec_nxt;
            pass_cnt   <= '0;
            ERR_CNT    <= '0;
            FIRST_FAIL <= '0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_CHECK;
          else           cnt   <= cnt - SETTLE_W'(1);
        end
        ST_CHECK: begin
          ERR_CNT <= err_nxt;
          if (mismatch && (ERR_CNT == '0)) FIRST_FAIL <= vec;
          if (idx != VEC_W'(31)) begin
            idx   <= idx_nxt;
            vec   <= vec_nxt;
            cnt   <= s;
            state <= ST_WAIT;
          end else if (pass_cnt < PASS_W'(NPASS - 1)) begin
            pass_cnt <= pass_cnt + PASS_W'(1);
            idx      <= idx_nxt;
            vec      <= vec_nxt;
            cnt      <= s;
            state    <= ST_WAIT;
          end else begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (err_nxt == '0);
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
